// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display reads > clear sweep > buffered writer pixels.
// The clear engine is built only when FB_CLEAR_EN is defined.
module fb_port_arbiter #(
  parameter int AW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk25M,
  input  logic          reset_n,
  input  logic          disp_rd,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_pix,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic          wr_data,
  output logic          wr_ready,
  input  logic          clr_start,
  input  logic          clr_val,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          ram_wd,
  input  logic          ram_q
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic          fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   fifo_count;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  logic          in_idle;
  logic          in_clear;
  logic          clr_slot;
  logic [AW-1:0] clr_ptr;
  logic          clr_fill;
  logic          disp_rd_q;

  assign fifo_empty = (fifo_count == '0);
  assign wr_ready   = (fifo_count != FULL_COUNT) && in_idle;
  assign push       = wr_valid && wr_ready;
  assign clr_slot   = !disp_rd && in_clear;
  assign pop        = !disp_rd && !in_clear && !fifo_empty;

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] clr_ptr_nxt;
  logic          clr_fill_nxt;
  logic          clr_done_nxt;

  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      clr_ptr  <= '0;
      clr_fill <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_ptr  <= clr_ptr_nxt;
      clr_fill <= clr_fill_nxt;
      clr_done <= clr_done_nxt;
    end
  end

  // The sweep only advances on cycles the display leaves free, so it never ends early.
  always_comb begin
    state_nxt    = state;
    clr_ptr_nxt  = clr_ptr;
    clr_fill_nxt = clr_fill;
    clr_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          clr_fill_nxt = clr_val;
          state_nxt    = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          clr_ptr_nxt = '0;
          state_nxt   = CLEAR;
        end
      end
      CLEAR: begin
        if (!disp_rd) begin
          clr_ptr_nxt = clr_ptr + AW'(1);
          if (clr_ptr == LAST_ADDR) begin
            state_nxt    = IDLE;
            clr_done_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_idle  = (state == IDLE);
  assign in_clear = (state == CLEAR);
  assign clr_busy = (state != IDLE);
`else
  logic unused_clr;

  assign unused_clr = clr_start ^ clr_val;
  assign in_idle    = 1'b1;
  assign in_clear   = 1'b0;
  assign clr_ptr    = '0;
  assign clr_fill   = 1'b0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
`endif

  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= 1'b0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= wr_addr;
        fifo_data[wr_ptr] <= wr_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    ram_addr = disp_addr;
    ram_we   = 1'b0;
    ram_wd   = 1'b0;
    if (disp_rd) begin
      ram_addr = disp_addr;
    end else if (clr_slot) begin
      ram_addr = clr_ptr;
      ram_we   = 1'b1;
      ram_wd   = clr_fill;
    end else if (pop) begin
      ram_addr = fifo_addr[rd_ptr];
      ram_we   = 1'b1;
      ram_wd   = fifo_data[rd_ptr];
    end
  end

  // ram_q belongs to the address presented last cycle, so qualify it with the delayed read flag.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      disp_rd_q <= 1'b0;
      disp_pix  <= 1'b0;
    end else begin
      disp_rd_q <= disp_rd;
      disp_pix  <= disp_rd_q ? ram_q : 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a RAM model and an in-order write scoreboard.
module tb_fb_port_arbiter;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int NADDR = 1 << AW;

  logic          clk25M = 1'b0;
  logic          reset_n = 1'b0;
  logic          disp_rd = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_pix;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_data = 1'b0;
  logic          wr_ready;
  logic          clr_start = 1'b0;
  logic          clr_val = 1'b0;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_wd;
  logic          ram_q = 1'b0;

  fb_port_arbiter #(.AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk25M(clk25M), .reset_n(reset_n),
    .disp_rd(disp_rd), .disp_addr(disp_addr), .disp_pix(disp_pix),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_val(clr_val), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wd(ram_wd), .ram_q(ram_q)
  );

  always #5 clk25M = ~clk25M;

  bit mem    [NADDR];
  bit shadow [NADDR];

  always @(posedge clk25M) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic          data;
    bit            is_clr;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  done_cnt = 0;
  int  last_clr_addr = -1;
  bit  model_busy = 1'b0;
  bit  done_exp = 1'b0;
  logic px_p0 = 1'b0;
  logic px_p1 = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs after the rising edge, then record what the bench expects to follow.
  task automatic applyStimulus(input logic rd, input logic [AW-1:0] da, input logic wv,
                               input logic [AW-1:0] wa, input logic wd,
                               input logic cs, input logic cv);
    @(posedge clk25M);
    #1;
    disp_rd   = rd;
    disp_addr = da;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
    clr_start = cs;
    clr_val   = cv;
    @(negedge clk25M);
    #1;
    if (wr_valid && wr_ready) exp_q.push_back('{wr_addr, wr_data, 1'b0});
`ifdef FB_CLEAR_EN
    if (clr_start && !model_busy) begin
      model_busy = 1'b1;
      for (int a = 0; a < NADDR; a++) exp_q.push_back('{a[AW-1:0], clr_val, 1'b1});
    end
`endif
  endtask

  always @(negedge clk25M) begin
    if (!reset_n) begin
      px_p0    = 1'b0;
      px_p1    = 1'b0;
      done_exp = 1'b0;
    end else begin
      checkOutput("disp_pix_pipe", disp_pix, px_p1);
      px_p1 = px_p0;
      px_p0 = disp_rd ? shadow[disp_addr] : 1'b0;
      checkOutput("clr_done_pulse", clr_done, done_exp);
      if (clr_done) done_cnt++;
      done_exp = 1'b0;
      if (ram_we) begin
        checkOutput("write_in_disp_slot", disp_rd, 0);
        tests++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("[TB] FAIL unexpected_write: observed addr 0x%0h expected no write", ram_addr);
        end
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          checkOutput("sb_addr", ram_addr, e.addr);
          checkOutput("sb_data", ram_wd, e.data);
          shadow[e.addr] = e.data;
          if (e.is_clr) begin
            last_clr_addr = e.addr;
            if (e.addr == AW'(NADDR - 1)) begin
              done_exp   = 1'b1;
              model_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    int acc;
    int done_before;

    repeat (3) @(posedge clk25M);
    #1;
    reset_n = 1'b1;
    @(negedge clk25M);
    #1;
    checkOutput("rst_wr_ready", wr_ready, 1);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_disp_pix", disp_pix, 0);
    checkOutput("rst_clr_busy", clr_busy, 0);
    checkOutput("rst_clr_done", clr_done, 0);

    // Single write then read back.
    applyStimulus(0, '0, 1, 10'h234, 1, 0, 0);
    checkOutput("wr_accept", wr_ready, 1);
    applyStimulus(0, '0, 0, '0, 0, 0, 0);
    checkOutput("wr_we", ram_we, 1);
    checkOutput("wr_addr", ram_addr, 10'h234);
    checkOutput("wr_wd", ram_wd, 1);
    applyStimulus(1, 10'h234, 0, '0, 0, 0, 0);
    checkOutput("rd_addr", ram_addr, 10'h234);
    applyStimulus(1, 10'h235, 0, '0, 0, 0, 0);
    applyStimulus(0, '0, 0, '0, 0, 0, 0);
    checkOutput("rd_pix_one", disp_pix, 1);
    applyStimulus(0, '0, 0, '0, 0, 0, 0);
    checkOutput("rd_pix_zero", disp_pix, 0);

    // Fill the FIFO while the display owns the port.
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 10'h010, 1, AW'(10'h100 + acc), acc[0], 0, 0);
      checkOutput("full_ready", wr_ready, (k < DEPTH) ? 1 : 0);
      checkOutput("full_no_we", ram_we, 0);
      if (wr_ready) acc++;
    end
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(0, '0, 0, '0, 0, 0, 0);
      checkOutput("drain_we", ram_we, 1);
      checkOutput("drain_addr", ram_addr, 10'h100 + k);
      if (k == 0) checkOutput("ready_at_pop", wr_ready, 0);
      if (k == 1) checkOutput("ready_after_pop", wr_ready, 1);
    end
    applyStimulus(0, '0, 0, '0, 0, 0, 0);
    checkOutput("drain_idle", ram_we, 0);

    // Queued writes followed by a clear request.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 10'h020, 1, AW'(10'h300 + k), 1'b0, 0, 0);
      checkOutput("pre_clr_ready", wr_ready, 1);
    end
    applyStimulus(1, 10'h020, 0, '0, 0, 1, 1);
    applyStimulus(1, 10'h020, 0, '0, 0, 0, 0);
`ifdef FB_CLEAR_EN
    checkOutput("drain_busy", clr_busy, 1);
    checkOutput("drain_wr_ready", wr_ready, 0);
`else
    checkOutput("noclr_busy", clr_busy, 0);
    checkOutput("noclr_wr_ready", wr_ready, 1);
`endif
    for (int c = 0; c < 3 * NADDR && exp_q.size() != 0; c++) begin
      applyStimulus(c[0], c[AW-1:0], 0, '0, 0, (c == 40) ? 1'b1 : 1'b0, 1'b0);
    end
    checkOutput("clr_all_written", exp_q.size(), 0);
    repeat (3) applyStimulus(0, '0, 0, '0, 0, 0, 0);
    checkOutput("clr_busy_fall", clr_busy, 0);
    checkOutput("clr_wr_ready", wr_ready, 1);
`ifdef FB_CLEAR_EN
    checkOutput("clr_done_count", done_cnt, 1);
`else
    checkOutput("noclr_done_count", done_cnt, 0);
`endif

    // Asynchronous reset in the middle of activity.
`ifdef FB_CLEAR_EN
    applyStimulus(0, '0, 0, '0, 0, 1, 0);
    for (int c = 0; c < 4 * NADDR && last_clr_addr != 'h100; c++) begin
      applyStimulus(c[0], c[AW-1:0], 0, '0, 0, 0, 0);
    end
    checkOutput("reached_0x100", last_clr_addr, 'h100);
    checkOutput("midclr_busy", clr_busy, 1);
`else
    applyStimulus(1, 10'h040, 1, 10'h3f0, 1, 0, 0);
    applyStimulus(1, 10'h040, 1, 10'h3f1, 1, 0, 0);
`endif
    done_before = done_cnt;
    #2;
    disp_rd   = 1'b0;
    wr_valid  = 1'b0;
    reset_n   = 1'b0;
    #1;
    checkOutput("arst_disp_pix", disp_pix, 0);
    checkOutput("arst_clr_busy", clr_busy, 0);
    checkOutput("arst_clr_done", clr_done, 0);
    checkOutput("arst_ram_we", ram_we, 0);
    checkOutput("arst_wr_ready", wr_ready, 1);
    exp_q.delete();
    model_busy = 1'b0;
    @(posedge clk25M);
    #1;
    reset_n = 1'b1;
    repeat (8) applyStimulus(0, '0, 0, '0, 0, 0, 0);
    checkOutput("no_done_after_reset", done_cnt, done_before);
    checkOutput("post_reset_busy", clr_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
